// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the shift-add multiply sequencer.
// Contents:
//   mul_state_t - sequencer FSM states
//   MUL_N/CNT_W - default datapath width and matching iteration-counter width
//   FLAG_*      - NZCV bit positions, shared with the ALU flag logic
//   make_nzcv   - packs four flag bits into NZCV order
package mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam int MUL_N = 32;
  localparam int CNT_W = $clog2(MUL_N) + 1;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic [3:0] make_nzcv(input logic n, input logic z,
                                           input logic c, input logic v);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/mul_sequencer_if.sv
// Request/response bundle between the main decoder/FSM and mul_sequencer.
// master: decoder side (drives start and operands, observes status/result).
// slave : sequencer side.
interface mul_sequencer_if #(parameter int N = 32);
  logic         start;
  logic         is_mla;
  logic         set_flags;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic [N-1:0] op_acc;
  logic [3:0]   flags_in;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic [3:0]   flags_out;
  logic         flags_we;

  modport master (
    output start, is_mla, set_flags, op_a, op_b, op_acc, flags_in,
    input  busy, done, result, flags_out, flags_we
  );

  modport slave (
    input  start, is_mla, set_flags, op_a, op_b, op_acc, flags_in,
    output busy, done, result, flags_out, flags_we
  );
endinterface

// File: rtl/mul_step.sv
// One shift-add multiply iteration (purely combinational).
// Inputs : acc, mcand, mplier - current partial sum, shifted multiplicand,
//          remaining multiplier.
// Outputs: acc_next, mcand_next, mplier_next - values after this iteration;
//          mplier_zero - the remaining multiplier after this step is zero.
module mul_step #(
  parameter int N = 32
) (
  input  logic [N-1:0] acc,
  input  logic [N-1:0] mcand,
  input  logic [N-1:0] mplier,
  output logic [N-1:0] acc_next,
  output logic [N-1:0] mcand_next,
  output logic [N-1:0] mplier_next,
  output logic         mplier_zero
);

  // Conditional add of the multiplicand, carry out of bit N-1 discarded.
  always_comb begin
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end else begin
      acc_next = acc;
    end
    mcand_next  = mcand << 1;
    mplier_next = mplier >> 1;
    mplier_zero = (mplier_next == {N{1'b0}});
  end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle shift-add sequencer for MUL/MULS/MLA/MLAS.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-high reset; aborts any operation in flight
//   bus   - mul_sequencer_if slave: start/operands/flags_in in,
//           busy/done/result/flags_out/flags_we out (all outputs registered)
// One multiplier bit is consumed per RUN cycle; DONE lasts one cycle and
// publishes the low N bits of op_a*op_b (+op_acc) and the NZCV update.
module mul_sequencer
  import mul_seq_pkg::*;
#(
  parameter int N         = MUL_N,
  parameter bit EARLY_OUT = 1'b0
) (
  input logic            clk,
  input logic            reset,
  mul_sequencer_if.slave bus
);

  localparam int CNT_WIDTH = $clog2(N) + 1;

  mul_state_t             state_r, state_next_s;
  logic [N-1:0]           acc_r, mcand_r, mplier_r;
  logic [N-1:0]           acc_nx_s, mcand_nx_s, mplier_nx_s;
  logic                   mplier_zero_s;
  logic [CNT_WIDTH-1:0]   count_r;
  logic                   set_flags_r;
  logic [1:0]             cv_r;
  logic                   load_s, step_s, finish_s, last_s;
  logic [3:0]             flags_nx_s;
  logic                   busy_r, done_r, flags_we_r;
  logic [N-1:0]           result_r;
  logic [3:0]             flags_out_r;

  mul_step #(.N(N)) u_step (
    .acc         (acc_r),
    .mcand       (mcand_r),
    .mplier      (mplier_r),
    .acc_next    (acc_nx_s),
    .mcand_next  (mcand_nx_s),
    .mplier_next (mplier_nx_s),
    .mplier_zero (mplier_zero_s)
  );

  // Last RUN cycle: N iterations done, or (early-out) nothing left to add.
  always_comb begin
    last_s = (count_r == CNT_WIDTH'(N - 1)) ||
             ((EARLY_OUT == 1'b1) && mplier_zero_s);
    flags_nx_s = make_nzcv(acc_nx_s[N-1], (acc_nx_s == {N{1'b0}}),
                           cv_r[1], cv_r[0]);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state and datapath control strobes.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    step_s       = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_next_s = RUN;
          load_s       = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (last_s) begin
          state_next_s = DONE;
          finish_s     = 1'b1;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        // A start seen here is dropped; the requester retries in IDLE.
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Operand capture and iteration registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r       <= {N{1'b0}};
      mcand_r     <= {N{1'b0}};
      mplier_r    <= {N{1'b0}};
      count_r     <= {CNT_WIDTH{1'b0}};
      set_flags_r <= 1'b0;
      cv_r        <= 2'b00;
    end else if (load_s) begin
      acc_r       <= bus.is_mla ? bus.op_acc : {N{1'b0}};
      mcand_r     <= bus.op_a;
      mplier_r    <= bus.op_b;
      count_r     <= {CNT_WIDTH{1'b0}};
      set_flags_r <= bus.set_flags;
      cv_r        <= {bus.flags_in[FLAG_C], bus.flags_in[FLAG_V]};
    end else if (step_s) begin
      acc_r       <= acc_nx_s;
      mcand_r     <= mcand_nx_s;
      mplier_r    <= mplier_nx_s;
      count_r     <= count_r + CNT_WIDTH'(1);
    end
  end

  // Registered outputs; result/flags_out load only when entering DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      flags_we_r  <= 1'b0;
      result_r    <= {N{1'b0}};
      flags_out_r <= 4'b0000;
    end else begin
      busy_r     <= (state_next_s != IDLE);
      done_r     <= finish_s;
      flags_we_r <= finish_s & set_flags_r;
      if (finish_s) begin
        result_r    <= acc_nx_s;
        flags_out_r <= flags_nx_s;
      end
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.flags_we  = flags_we_r;
  assign bus.result    = result_r;
  assign bus.flags_out = flags_out_r;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: one instance with fixed N iterations
// and one with early-out, driven by directed and random operations and
// compared against an arithmetic reference model.
module tb_mul_sequencer;

  localparam int N = 32;

  logic clk;
  logic reset;

  int n_checks;
  int n_fail;

  mul_sequencer_if #(.N(N)) if0 ();
  mul_sequencer_if #(.N(N)) if1 ();

  mul_sequencer #(.N(N), .EARLY_OUT(1'b0)) u_dut_fixed (
    .clk   (clk),
    .reset (reset),
    .bus   (if0.slave)
  );

  mul_sequencer #(.N(N), .EARLY_OUT(1'b1)) u_dut_early (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: low N bits of a*b (+acc), plain arithmetic.
  function automatic logic [N-1:0] ref_result(input logic [N-1:0] a, input logic [N-1:0] b,
                                              input logic [N-1:0] c, input bit mla);
    logic [2*N-1:0] p;
    p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    if (mla) p = p + {{N{1'b0}}, c};
    return p[N-1:0];
  endfunction

  // Reference: cycles from the accepted-start cycle to the done cycle.
  function automatic int ref_latency(input bit early, input logic [N-1:0] b);
    int runs;
    runs = N;
    if (early) begin
      runs = 1;
      for (int i = 0; i < N; i++) begin
        if (b[i]) runs = i + 1;
      end
    end
    return runs + 1;
  endfunction

  task automatic drive(input bit sel, input bit st, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] c, input bit mla, input bit sf, input logic [3:0] fin);
    if (sel) begin
      if1.start = st; if1.op_a = a; if1.op_b = b; if1.op_acc = c;
      if1.is_mla = mla; if1.set_flags = sf; if1.flags_in = fin;
    end else begin
      if0.start = st; if0.op_a = a; if0.op_b = b; if0.op_acc = c;
      if0.is_mla = mla; if0.set_flags = sf; if0.flags_in = fin;
    end
  endtask

  task automatic sample(input bit sel, output logic busy, output logic done, output logic we,
                        output logic [N-1:0] res, output logic [3:0] fl);
    if (sel) begin
      busy = if1.busy; done = if1.done; we = if1.flags_we; res = if1.result; fl = if1.flags_out;
    end else begin
      busy = if0.busy; done = if0.done; we = if0.flags_we; res = if0.result; fl = if0.flags_out;
    end
  endtask

  // Issue one operation and check timing, result, flags and pulse counts.
  // extra_start keeps start high one more cycle with different operands.
  task automatic do_op(input string tag, input bit sel, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] c, input bit mla, input bit sf, input logic [3:0] fin,
                       input bit extra_start);
    logic busy, done, we;
    logic [N-1:0] res, exp_res, res_at_done;
    logic [3:0] fl, exp_fl, fl_at_done;
    int n_done, n_we, done_cyc, exp_lat;
    logic busy_after, we_at_done;
    exp_res = ref_result(a, b, c, mla);
    exp_fl = {exp_res[N-1], (exp_res == '0), fin[1], fin[0]};
    exp_lat = ref_latency(sel, b);
    n_done = 0; n_we = 0; done_cyc = -1; busy_after = 1'b1; we_at_done = 1'b0;
    res_at_done = '0; fl_at_done = 4'b0000;
    drive(sel, 1'b1, a, b, c, mla, sf, fin);
    for (int cyc = 1; cyc <= N + 8; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1 && extra_start)
        drive(sel, 1'b1, ~a, b ^ 32'h0000_0F0F, ~c, ~mla, ~sf, ~fin);
      else
        drive(sel, 1'b0, $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), 4'($urandom));
      sample(sel, busy, done, we, res, fl);
      if (cyc == 1) chk_eq({tag, " busy_rise"}, {63'd0, busy}, 64'd1);
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = cyc; res_at_done = res; fl_at_done = fl; we_at_done = we;
        end
      end
      if (we) n_we++;
      if (done_cyc > 0 && cyc == done_cyc + 1) busy_after = busy;
    end
    sample(sel, busy, done, we, res, fl);
    chk_eq({tag, " done_count"}, 64'(n_done), 64'd1);
    chk_eq({tag, " done_cycle"}, 64'(done_cyc), 64'(exp_lat));
    chk_eq({tag, " result"}, {32'd0, res_at_done}, {32'd0, exp_res});
    chk_eq({tag, " flags_we_at_done"}, {63'd0, we_at_done}, {63'd0, sf});
    chk_eq({tag, " flags_we_count"}, 64'(n_we), 64'(sf));
    if (sf) chk_eq({tag, " flags_out"}, {60'd0, fl_at_done}, {60'd0, exp_fl});
    chk_eq({tag, " busy_after_done"}, {63'd0, busy_after}, 64'd0);
    chk_eq({tag, " result_held"}, {32'd0, res}, {32'd0, exp_res});
  endtask

  initial begin
    logic busy, done, we;
    logic [N-1:0] res;
    logic [3:0] fl;
    int aborted_done;
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 4'b0000);
    drive(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    sample(1'b0, busy, done, we, res, fl);
    chk_eq("reset_outputs", {busy, done, we, 4'b0000, fl, res}, 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    do_op("mul_3x5", 1'b0, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 4'b0000, 1'b0);
    do_op("muls_ffff", 1'b0, 32'h0000_FFFF, 32'h0001_0001, 32'd0, 1'b0, 1'b1, 4'b0011, 1'b0);
    do_op("mlas_zero", 1'b0, 32'd0, 32'd7, 32'd0, 1'b1, 1'b1, 4'b0000, 1'b0);
    do_op("mla_wrap", 1'b0, 32'h8000_0000, 32'd2, 32'd5, 1'b1, 1'b0, 4'b0000, 1'b0);
    do_op("mul_allones", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 4'b1100, 1'b0);
    do_op("start_ignored", 1'b0, 32'd1234, 32'd5678, 32'd99, 1'b1, 1'b0, 4'b0010, 1'b1);

    // Abort mid-RUN with reset: outputs clear at once, no done afterwards.
    drive(1'b0, 1'b1, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 4'b0000);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 4'b0000);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    sample(1'b0, busy, done, we, res, fl);
    chk_eq("reset_mid_run", {busy, done, we, 4'b0000, fl, res}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    aborted_done = 0;
    for (int i = 0; i < N + 4; i++) begin
      @(posedge clk);
      #1;
      sample(1'b0, busy, done, we, res, fl);
      if (done || we || busy) aborted_done++;
    end
    chk_eq("no_done_after_abort", 64'(aborted_done), 64'd0);
    do_op("mul_6x7", 1'b0, 32'd6, 32'd7, 32'd0, 1'b0, 1'b0, 4'b0000, 1'b0);

    do_op("early_b1", 1'b1, 32'h1234_5678, 32'd1, 32'd0, 1'b0, 1'b1, 4'b0001, 1'b0);
    do_op("early_b0_mla", 1'b1, 32'hDEAD_BEEF, 32'd0, 32'h0BAD_F00D, 1'b1, 1'b1, 4'b0010, 1'b0);
    do_op("early_msb", 1'b1, 32'd3, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 4'b0000, 1'b0);

    for (int k = 0; k < 6; k++) begin
      do_op("rand_fixed", 1'b0, $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom),
            4'($urandom), 1'($urandom));
      do_op("rand_early", 1'b1, $urandom, $urandom >> $urandom_range(0, 31), $urandom,
            1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
